uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmitter: configurable data width, stop-bit count and baud divisor, with an input FIFO so the producer can queue several characters while a frame is in flight. Accepts characters on a `ready` strobe, serialises them LSB-first on `txD`, and reports buffer space on `tdre`. It sits between the system bus/producer logic and the serial output pin, replacing the fixed 8N1 single-buffer transmitter.

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB first; optional parity via UART_TX_PARITY_EN
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          ready,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          txD,
    output logic                          tdre,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BDW = $clog2(CLK_DIV);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    generate
        if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
            $error("uart_tx_fifo: illegal parameter value");
        end
    endgenerate
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par, par_n;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t                 state, state_n;
    logic [BDW-1:0]         baud, baud_n;
    logic [3:0]             bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   sh, sh_n;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count_n;
    logic                   txd_n, pop, wr_en, full, has_data, tick;
    assign full     = fifo_count == FULL;
    assign has_data = fifo_count != '0;
    assign wr_en    = ready && !full;
    assign tick     = baud == BDW'(CLK_DIV - 1);
    assign busy     = state != IDLE;
    assign count_n  = fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
    // Next-state logic: bit timing, frame sequencing and FIFO pops
    always_comb begin
        state_n = state;
        baud_n  = (state == IDLE || tick) ? '0 : baud + 1'b1;
        bit_n   = bit_cnt;
        sh_n    = sh;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: if (has_data) begin
                pop     = 1'b1;
                state_n = START;
            end
            START: if (tick) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (tick) begin
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                    bit_n   = '0;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                    sh_n  = sh >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_n = STOP;
                bit_n   = '0;
            end
`endif
            STOP: if (tick) begin
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                    pop     = has_data;
                    state_n = has_data ? START : IDLE;
                    bit_n   = '0;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            sh_n  = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_n = ^mem[rd_ptr] ^ (PARITY_ODD != 0);
`endif
        end
`ifdef UART_TX_PARITY_EN
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`endif
    end
    // Transmit state registers; txD is registered so the pin never glitches
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            txD     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            sh      <= sh_n;
            txD     <= txd_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end
    // FIFO bookkeeping; full is judged before the edge so a same-cycle pop cannot rescue a write
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tdre       <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(wr_en);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= count_n;
            tdre       <= count_n != FULL;
            overflow   <= overflow | (ready && full);
        end
    end
    // FIFO storage needs no reset; only the pointers define valid contents
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO flow, overflow and mid-frame reset
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam int FC = FL * 4;
    logic       clk = 1'b0, clr = 1'b1, ready = 1'b0;
    logic [7:0] tx_data = '0;
    logic       txd0, tdre0, busy0, ovf0, txd1, tdre1, busy1, ovf1;
    logic [2:0] cnt0, cnt1;
    int         total = 0, bad = 0;
    typedef struct {logic [7:0] d; logic pe;} vec_t;
    vec_t vt[5];

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u0 (
        .clk(clk), .clr(clr), .ready(ready), .tx_data(tx_data), .txD(txd0),
        .tdre(tdre0), .busy(busy0), .fifo_count(cnt0), .overflow(ovf0));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)) u1 (
        .clk(clk), .clr(clr), .ready(ready), .tx_data(tx_data), .txD(txd1),
        .tdre(tdre1), .busy(busy1), .fifo_count(cnt1), .overflow(ovf1));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic p, input int j);
        int k = j / 4;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return p;
`endif
        return 1'b1;
    endfunction

    task automatic write(input logic [7:0] d);
        ready = 1'b1;
        tx_data = d;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic stream(input logic [7:0] d0, input logic p0, input logic [7:0] d1, input logic p1, input int nf);
        for (int j = 0; j < nf * FC; j++) begin
            logic [7:0] d = (j < FC) ? d0 : d1;
            logic       p = (j < FC) ? p0 : p1;
            chk("txd_even", txd0, exp_bit(d, p, j % FC));
            chk("txd_odd", txd1, exp_bit(d, ~p, j % FC));
            chk("busy_frame", busy0, 1);
            chk("tdre_frame", tdre0, 1);
            chk("cnt_frame", cnt0, (j < FC * (nf - 1)) ? 1 : 0);
            @(negedge clk);
        end
        chk("txd_idle", txd0, 1);
        chk("busy_idle", busy0, 0);
    endtask

    initial begin
        int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
        int quiet;
        vt[0] = '{8'hAA, 1'b0};
        vt[1] = '{8'h01, 1'b1};
        vt[2] = '{8'hFF, 1'b0};
        vt[3] = '{8'h5A, 1'b0};
        vt[4] = '{8'h80, 1'b1};
        @(negedge clk);
        clr = 1'b0;
        chk("rst_txd", txd0, 1);
        chk("rst_tdre", tdre0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_txd_odd", txd1, 1);
        repeat (2) @(negedge clk);
        foreach (vt[i]) begin
            write(vt[i].d);
            chk("single_cnt_queued", cnt0, 1);
            chk("single_txd_pre", txd0, 1);
            chk("single_busy_pre", busy0, 0);
            @(negedge clk);
            stream(vt[i].d, vt[i].pe, 8'h00, 1'b0, 1);
            repeat (3) @(negedge clk);
        end
        write(8'h55);
        chk("b2b_cnt_1", cnt0, 1);
        write(8'h0F);
        chk("b2b_cnt_2", cnt0, 1);
        stream(8'h55, 1'b0, 8'h0F, 1'b0, 2);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            write(8'h11 * (k + 1));
            chk("ovf_cnt", cnt0, exp_cnt[k]);
            chk("ovf_tdre", tdre0, k >= 4 ? 0 : 1);
            chk("ovf_flag", ovf0, k == 5 ? 1 : 0);
        end
        for (int i = 0; i < FC + 10 && !tdre0; i++) @(negedge clk);
        chk("ovf_tdre_after_pop", tdre0, 1);
        chk("ovf_cnt_after_pop", cnt0, 3);
        chk("ovf_sticky_pop", ovf0, 1);
        for (int i = 0; i < 5 * FC + 20 && (busy0 || cnt0 != 0); i++) @(negedge clk);
        chk("ovf_drain_busy", busy0, 0);
        chk("ovf_drain_cnt", cnt0, 0);
        chk("ovf_sticky_idle", ovf0, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_cleared", ovf0, 0);
        repeat (2) @(negedge clk);
        write(8'hF7);
        write(8'h12);
        write(8'h34);
        repeat (16) @(negedge clk);
        chk("mid_txd_bit3", txd0, 0);
        chk("mid_cnt", cnt0, 2);
        chk("mid_busy", busy0, 1);
        clr = 1'b1;
        #1;
        chk("mid_rst_txd", txd0, 1);
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_tdre", tdre0, 1);
        @(negedge clk);
        clr = 1'b0;
        quiet = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0) quiet = 0;
        end
        chk("mid_rst_quiet", quiet, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
